// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V run controller and its retirement trace FIFO.
// Holds the default datapath width, the ebreak encoding, halt-cause codes and FSM states.
package riscv_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_BUDGET = 2'd1,
        CAUSE_EBREAK = 2'd2,
        CAUSE_ABORT  = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } run_state_e;

endpackage

// File: rtl/riscv_trace_fifo.sv
// Synchronous show-ahead FIFO for retirement trace entries.
// The head is presented combinationally; a push into an empty FIFO is visible after the edge.
module riscv_trace_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    // A pop frees the slot this same edge, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: clock-enable gating, retire counting,
// halt detection (budget / ebreak / abort) and a retirement trace FIFO drained by a debug port.
module riscv_run_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN          = XLEN_DEF,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned CNT_W         = 16,
    parameter bit          STALL_ON_FULL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         max_cycles,
    input  logic                     halt_on_ebreak,
    input  logic [XLEN-1:0]          PC,
    input  logic [XLEN-1:0]          instruction,
    input  logic [XLEN-1:0]          ALU_Result,
    output logic                     core_en,
    output logic                     running,
    output logic                     done,
    output logic [1:0]               done_cause,
    output logic [CNT_W-1:0]         retired,
    input  logic                     pop,
    output logic                     trace_valid,
    output logic [XLEN-1:0]          trace_pc,
    output logic [XLEN-1:0]          trace_instr,
    output logic [XLEN-1:0]          trace_result,
    output logic [$clog2(DEPTH):0]   trace_level,
    output logic                     overflow
);

    run_state_e          state;
    run_state_e          state_nxt;
    cause_e              cause_q;
    cause_e              cause_nxt;
    logic [CNT_W-1:0]    budget_q;
    logic                ebreak_en_q;
    logic [CNT_W-1:0]    retired_q;
    logic                overflow_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [3*XLEN-1:0]   fifo_rdata;

    logic                start_ok;
    logic                retire;
    logic                hit_ebreak;
    logic                hit_budget;
    logic                drop;

    assign start_ok = start && (state != ST_RUN);

    assign core_en = (state == ST_RUN) && !(STALL_ON_FULL && fifo_full && !pop);
    assign retire  = core_en && !abort;

    assign hit_ebreak = ebreak_en_q && (instruction == XLEN'(EBREAK));
    assign hit_budget = (budget_q != '0) && ((retired_q + 1'b1) == budget_q);

    // Only reachable with STALL_ON_FULL=0: with stalling, retire already excludes full && !pop.
    assign drop = retire && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    cause_nxt = CAUSE_NONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_ABORT;
                end else if (retire && hit_ebreak) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_EBREAK;
                end else if (retire && hit_budget) begin
                    state_nxt = ST_DONE;
                    cause_nxt = CAUSE_BUDGET;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            budget_q    <= '0;
            ebreak_en_q <= 1'b0;
            retired_q   <= '0;
            overflow_q  <= 1'b0;
        end else if (start_ok) begin
            budget_q    <= max_cycles;
            ebreak_en_q <= halt_on_ebreak;
            retired_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (retire && (retired_q != '1)) begin
                retired_q <= retired_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    riscv_trace_fifo #(
        .WIDTH (3*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start_ok),
        .push  (retire),
        .pop   (pop),
        .wdata ({PC, instruction, ALU_Result}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (trace_level)
    );

    assign running      = (state == ST_RUN);
    assign done         = (state == ST_DONE);
    assign done_cause   = cause_q;
    assign retired      = retired_q;
    assign overflow     = overflow_q;
    assign trace_valid  = !fifo_empty;
    assign trace_pc     = fifo_rdata[3*XLEN-1:2*XLEN];
    assign trace_instr  = fifo_rdata[2*XLEN-1:XLEN];
    assign trace_result = fifo_rdata[XLEN-1:0];

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Scoreboard bench for riscv_run_ctrl: three instances (DEPTH 16 stalling, DEPTH 4 stalling,
// DEPTH 4 dropping) share stimulus; a monitor checks the selected instance's popped entries and halt status.
module tb_riscv_run_ctrl;

    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] AKEY = 32'hA5A5_0F0F;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] res;
    } entry_t;

    typedef struct {
        logic [1:0]  cause;
        logic [15:0] retired;
        logic [4:0]  level;
        logic        ovf;
    } status_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pop = 1'b0;
    logic        halt_on_ebreak = 1'b0;
    logic        ebreak_prog = 1'b0;
    logic [15:0] max_cycles = '0;
    logic [1:0]  sel = 2'd0;

    logic [31:0] pc_w [3];
    logic [31:0] instr_w [3];
    logic [31:0] alu_w [3];
    logic [31:0] tpc_w [3];
    logic [31:0] tins_w [3];
    logic [31:0] tres_w [3];
    logic        core_en_w [3];
    logic        running_w [3];
    logic        done_w [3];
    logic        tvalid_w [3];
    logic        ovf_w [3];
    logic [1:0]  cause_w [3];
    logic [15:0] retired_w [3];
    logic [4:0]  lvl_w [3];
    logic [4:0]  lvl16;
    logic [2:0]  lvl4s;
    logic [2:0]  lvl4d;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    entry_t      exp_q[$];
    status_t     st_q[$];

    always #5 clk = ~clk;

    // Core stand-in: PC restarts on start and advances only while the core is enabled.
    for (genvar g = 0; g < 3; g++) begin : g_core
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n)             pc_w[g] <= '0;
            else if (start)         pc_w[g] <= '0;
            else if (core_en_w[g])  pc_w[g] <= pc_w[g] + 32'd4;
        end
        assign instr_w[g] = (ebreak_prog && pc_w[g] == 32'd12) ? EBRK : {pc_w[g][11:0], 20'h00013};
        assign alu_w[g]   = pc_w[g] ^ AKEY;
    end

    assign lvl_w[0] = lvl16;
    assign lvl_w[1] = {2'b00, lvl4s};
    assign lvl_w[2] = {2'b00, lvl4d};

    riscv_run_ctrl #(.XLEN(32), .DEPTH(16), .CNT_W(16), .STALL_ON_FULL(1'b1)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_cycles(max_cycles),
        .halt_on_ebreak(halt_on_ebreak), .PC(pc_w[0]), .instruction(instr_w[0]), .ALU_Result(alu_w[0]),
        .core_en(core_en_w[0]), .running(running_w[0]), .done(done_w[0]), .done_cause(cause_w[0]),
        .retired(retired_w[0]), .pop(pop), .trace_valid(tvalid_w[0]), .trace_pc(tpc_w[0]),
        .trace_instr(tins_w[0]), .trace_result(tres_w[0]), .trace_level(lvl16), .overflow(ovf_w[0]));

    riscv_run_ctrl #(.XLEN(32), .DEPTH(4), .CNT_W(16), .STALL_ON_FULL(1'b1)) u4s (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_cycles(max_cycles),
        .halt_on_ebreak(halt_on_ebreak), .PC(pc_w[1]), .instruction(instr_w[1]), .ALU_Result(alu_w[1]),
        .core_en(core_en_w[1]), .running(running_w[1]), .done(done_w[1]), .done_cause(cause_w[1]),
        .retired(retired_w[1]), .pop(pop), .trace_valid(tvalid_w[1]), .trace_pc(tpc_w[1]),
        .trace_instr(tins_w[1]), .trace_result(tres_w[1]), .trace_level(lvl4s), .overflow(ovf_w[1]));

    riscv_run_ctrl #(.XLEN(32), .DEPTH(4), .CNT_W(16), .STALL_ON_FULL(1'b0)) u4d (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_cycles(max_cycles),
        .halt_on_ebreak(halt_on_ebreak), .PC(pc_w[2]), .instruction(instr_w[2]), .ALU_Result(alu_w[2]),
        .core_en(core_en_w[2]), .running(running_w[2]), .done(done_w[2]), .done_cause(cause_w[2]),
        .retired(retired_w[2]), .pop(pop), .trace_valid(tvalid_w[2]), .trace_pc(tpc_w[2]),
        .trace_instr(tins_w[2]), .trace_result(tres_w[2]), .trace_level(lvl4d), .overflow(ovf_w[2]));

    logic        s_core_en, s_running, s_done, s_tvalid, s_ovf;
    logic [1:0]  s_cause;
    logic [15:0] s_retired;
    logic [4:0]  s_level;
    logic [31:0] s_tpc, s_tins, s_tres;

    assign s_core_en = core_en_w[sel];
    assign s_running = running_w[sel];
    assign s_done    = done_w[sel];
    assign s_tvalid  = tvalid_w[sel];
    assign s_ovf     = ovf_w[sel];
    assign s_cause   = cause_w[sel];
    assign s_retired = retired_w[sel];
    assign s_level   = lvl_w[sel];
    assign s_tpc     = tpc_w[sel];
    assign s_tins    = tins_w[sel];
    assign s_tres    = tres_w[sel];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [31:0] exp_insn(input logic [31:0] pc, input logic eb);
        return (eb && pc == 32'd12) ? EBRK : {pc[11:0], 20'h00013};
    endfunction

    task automatic expect_entries(input int unsigned n, input logic eb);
        for (int unsigned i = 0; i < n; i++) begin
            logic [31:0] p;
            p = 32'(i * 4);
            exp_q.push_back('{pc: p, instr: exp_insn(p, eb), res: p ^ AKEY});
        end
    endtask

    task automatic expect_status(input logic [1:0] c, input logic [15:0] r, input logic [4:0] l, input logic o);
        st_q.push_back('{cause: c, retired: r, level: l, ovf: o});
    endtask

    // Called at posedge+1; start is sampled on the following edge.
    task automatic do_start(input logic [15:0] mc, input logic heb, input logic eb);
        max_cycles     = mc;
        halt_on_ebreak = heb;
        ebreak_prog    = eb;
        start          = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
    endtask

    task automatic wait_done(input int unsigned limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if (s_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now(name);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int unsigned limit, input string name);
        for (int unsigned i = 0; i < limit; i++) begin
            pop = s_tvalid;
            if (!s_tvalid) break;
            @(posedge clk); #1;
        end
        if (pop) fail_now(name);
        pop = 1'b0;
    endtask

    // Monitor: compares every dequeued head and the status at each rising done.
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (pop && s_tvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL trace_extra: got pc %0h expected no entry", s_tpc);
                end else begin
                    entry_t e;
                    e = exp_q.pop_front();
                    check("trace_pc", 64'(s_tpc), 64'(e.pc));
                    check("trace_instr", 64'(s_tins), 64'(e.instr));
                    check("trace_result", 64'(s_tres), 64'(e.res));
                end
            end
            if (s_done && !done_prev && st_q.size() != 0) begin
                status_t s;
                s = st_q.pop_front();
                check("done_cause", 64'(s_cause), 64'(s.cause));
                check("retired", 64'(s_retired), 64'(s.retired));
                check("trace_level", 64'(s_level), 64'(s.level));
                check("overflow", 64'(s_ovf), 64'(s.ovf));
            end
            done_prev = s_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_en", 64'(s_core_en), 64'd0);
        check("rst_running", 64'(s_running), 64'd0);
        check("rst_done", 64'(s_done), 64'd0);
        check("rst_cause", 64'(s_cause), 64'd0);
        check("rst_retired", 64'(s_retired), 64'd0);
        check("rst_level", 64'(s_level), 64'd0);
        check("rst_valid", 64'(s_tvalid), 64'd0);
        check("rst_trace_pc", 64'(s_tpc), 64'd0);
        check("rst_overflow", 64'(s_ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Budget of 6 on the deep FIFO.
        sel = 2'd0;
        expect_entries(6, 1'b0);
        expect_status(2'd1, 16'd6, 5'd6, 1'b0);
        do_start(16'd6, 1'b0, 1'b0);
        wait_done(30, "budget6_done");
        check("budget6_core_en_low", 64'(s_core_en), 64'd0);
        drain(30, "budget6_drain");

        // ebreak as the 4th instruction, unlimited budget.
        expect_entries(4, 1'b1);
        expect_status(2'd2, 16'd4, 5'd4, 1'b0);
        do_start(16'd0, 1'b1, 1'b1);
        wait_done(30, "ebreak_done");
        drain(30, "ebreak_drain");

        // Stall on full FIFO (DEPTH 4), then release by popping.
        sel = 2'd1;
        expect_entries(10, 1'b0);
        expect_status(2'd1, 16'd10, 5'd4, 1'b0);
        do_start(16'd10, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("stall_core_en", 64'(s_core_en), 64'd0);
        check("stall_retired", 64'(s_retired), 64'd4);
        check("stall_level", 64'(s_level), 64'd4);
        check("stall_running", 64'(s_running), 64'd1);
        @(posedge clk); #1;
        pop = 1'b1;
        #1;
        check("stall_release", 64'(s_core_en), 64'd1);
        drain(40, "stall_drain");
        check("stall_done", 64'(s_done), 64'd1);

        // Drop-on-full with DEPTH 4: keeps the first 4 entries.
        sel = 2'd2;
        expect_entries(4, 1'b0);
        expect_status(2'd1, 16'd8, 5'd4, 1'b1);
        do_start(16'd8, 1'b0, 1'b0);
        wait_done(30, "drop_done");
        drain(30, "drop_drain");

        // Abort in the same cycle as the budget hit.
        sel = 2'd0;
        expect_entries(2, 1'b0);
        expect_status(2'd3, 16'd2, 5'd2, 1'b0);
        do_start(16'd3, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done(10, "abort_done");
        drain(30, "abort_drain");

        // Asynchronous reset mid-run with 3 entries queued.
        do_start(16'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_level", 64'(s_level), 64'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_running", 64'(s_running), 64'd0);
        check("mid_rst_core_en", 64'(s_core_en), 64'd0);
        check("mid_rst_done", 64'(s_done), 64'd0);
        check("mid_rst_retired", 64'(s_retired), 64'd0);
        check("mid_rst_level", 64'(s_level), 64'd0);
        check("mid_rst_valid", 64'(s_tvalid), 64'd0);
        check("mid_rst_trace_pc", 64'(s_tpc), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_entries(2, 1'b0);
        expect_status(2'd1, 16'd2, 5'd2, 1'b0);
        do_start(16'd2, 1'b0, 1'b0);
        wait_done(20, "post_rst_done");
        drain(20, "post_rst_drain");

        repeat (2) @(posedge clk);
        check("trace_expect_left", 64'(exp_q.size()), 64'd0);
        check("status_expect_left", 64'(st_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_run_ctrl.md
# riscv_run_ctrl

Parametrised run controller and retirement trace buffer for the single-cycle RISC-V core.
- Gates the core with a clock enable and counts retired instructions.
- Halts on a cycle budget, on `ebreak`, or on abort.
- Captures {PC, instruction, ALU_Result} per retired instruction into a show-ahead FIFO that a bench or debug port drains.
- Replaces fixed-length "run N clocks then stop" sequencing with a reusable, synthesizable block that sits beside `RISCV_architecture`.

## Interface
Parameters:
- `XLEN`, 32, datapath width of PC/instruction/result fields
- `DEPTH`, 16, trace FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of retire counter and budget
- `STALL_ON_FULL`, 1, 1 = stall core while FIFO full; 0 = drop entries and flag overflow

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: core clock
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: pulse; begins a run from IDLE or DONE
- `abort` in 1: forces the run to end
- `max_cycles` in CNT_W: retire budget; 0 = unlimited; sampled on `start`
- `halt_on_ebreak` in 1: enables the `ebreak` halt; sampled on `start`
- `PC` in XLEN: current core PC
- `instruction` in XLEN: current core instruction
- `ALU_Result` in XLEN: current core ALU result
- `core_en` out 1: core clock enable
- `running` out 1: state is RUN
- `done` out 1: state is DONE
- `done_cause` out 2: reason for the halt; 0 none, 1 budget, 2 ebreak, 3 abort
- `retired` out CNT_W: instructions retired in this run
- `pop` in 1: dequeue the FIFO head
- `trace_valid` out 1: FIFO non-empty
- `trace_pc` out XLEN: head entry PC
- `trace_instr` out XLEN: head entry instruction
- `trace_result` out XLEN: head entry ALU result
- `trace_level` out $clog2(DEPTH)+1: FIFO occupancy
- `overflow` out 1: sticky; an entry was dropped

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE on a halt condition.
  - DONE→RUN on `start`.
  - `start` while in RUN is ignored.
- `start` does all of the following at once:
  - latches `max_cycles` and `halt_on_ebreak`
  - clears `retired`, `overflow`, `done_cause`
  - flushes the FIFO
- `core_en` = RUN && !(STALL_ON_FULL && full && !pop). The output is combinational.
- Retire event: a rising edge with `core_en`=1 and `abort`=0. On a retire event:
  - `retired` increments, saturating at 2^CNT_W−1.
  - {PC, instruction, ALU_Result} is pushed to the FIFO.
  - If STALL_ON_FULL=0 and the FIFO is full without a `pop`, the entry is dropped and `overflow` is set.
- Halt conditions, evaluated on the retire edge. Priority when several hold: abort > ebreak > budget.
  - Budget: `max_cycles`≠0 and `retired`+1 == `max_cycles`. Cause 1.
  - Ebreak: latched enable and `instruction` == 32'h0010_0073. The ebreak entry is pushed. Cause 2.
- Abort: in RUN, `abort`=1 moves to DONE on the next edge, with no push and no count. Cause 3. Abort in IDLE or DONE is ignored.
- FIFO behaviour:
  - Show-ahead: `trace_*` shows the head whenever `trace_valid`=1.
  - `pop` while empty is ignored.
  - Push and pop in the same cycle while full: both occur and the level is unchanged.
  - The FIFO stays readable in DONE and IDLE.

## Timing
- Reset values:
  - state IDLE
  - `core_en`, `running`, `done`, `overflow`, `trace_valid` = 0
  - `done_cause`, `retired`, `trace_level` = 0
  - FIFO empty
  - `trace_*` = 0
- `start` at edge k: `running`=1 after k and `core_en`=1 in cycle k+1. The first retire is at edge k+1.
- Budget N: exactly N retire edges, then `done`=1 right after the Nth. `core_en` is low from then on.
- A pushed entry is visible on `trace_*` one edge after the push when the FIFO was empty (no fall-through).
- Stall release: `pop` asserted while full raises `core_en` in the same cycle.
- Pointers wrap modulo DEPTH. `trace_level` reaches DEPTH when full.
- Reset mid-run returns to the reset values immediately and asynchronously.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN` default
  - `EBREAK` encoding constant
  - `done_cause` codes
  - FSM state enum
- Sub-module `riscv_trace_fifo`: synchronous show-ahead FIFO, parametrised by width 3·XLEN and DEPTH. Outputs are full, empty and level.
- The top level holds the FSM, the counter, halt detection and the overflow flag.

## Test plan
- Reset, then `start` with `max_cycles`=6: exactly 6 retires; `done`=1; `done_cause`=1; `retired`=6; `trace_level`=6; the popped PCs match the core sequence.
- `halt_on_ebreak`=1, program with `ebreak` as the 4th instruction, `max_cycles`=0: halt with `done_cause`=2 and `retired`=4; the last entry has instruction 32'h0010_0073.
- DEPTH=4, STALL_ON_FULL=1, `max_cycles`=10, no pops until full: `core_en` drops at level 4 and `retired` holds at 4. Pop one per cycle and the run completes to 10 with `overflow`=0.
- STALL_ON_FULL=0, DEPTH=4, `max_cycles`=8, no pops: `retired`=8, `trace_level`=4, `overflow`=1; the FIFO holds the first 4 entries.
- `abort` at the 3rd RUN cycle, same cycle as a budget hit: `done_cause`=3; 2 entries are pushed.
- Assert `rst_n` low mid-run with level 3: all outputs return to reset values at once; a subsequent `start` runs normally.
